// File: rtl/mem_access_unit.sv
// mem_access_unit: single-request load/store engine onto a simple req/ack/err bus.
// Aligned accesses take one bus beat; misaligned accesses fault with addr_fault.
// Optional feature macro MEM_ACCESS_UNIT_SPLIT_EN: misaligned accesses are serviced,
// using a second beat when the access crosses a bus-word boundary.
//
// state | meaning
// IDLE  | waiting for available
// BEAT1 | first (or only) bus beat outstanding
// BEAT2 | second beat of a boundary-crossing access
// DONE  | one-cycle completion, results valid
module mem_access_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              available,
    input  logic              is_write,
    input  logic              is_unsigned,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   in,
    output logic [XLEN-1:0]   out,
    output logic              busy,
    output logic              done,
    output logic              op_fault,
    output logic              addr_fault,
    output logic              access_fault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_wstrb,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [XLEN-1:0]   bus_rdata
);
    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} state_t;

    state_t            r_state;
    logic              r_busy, r_done;
    logic              r_op_fault, r_addr_fault, r_access_fault;
    logic [XLEN-1:0]   r_out;
    logic              r_bus_req, r_bus_we;
    logic [XLEN-1:0]   r_bus_addr, r_bus_wdata;
    logic [BYTES-1:0]  r_bus_wstrb;
    logic [7:0]        r_cnt;
    logic [1:0]        r_op;
    logic              r_uns;
    logic              r_we;
    logic [OFFW-1:0]   r_off;

    logic              w_op_ok;
    logic [3:0]        w_nbytes;
    logic [OFFW-1:0]   w_off;
    logic [OFFW+2:0]   w_sh;
    logic [OFFW+2:0]   w_rsh;
    logic [XLEN-1:0]   w_base;
    logic [XLEN-1:0]   w_wdata1;
    logic [BYTES-1:0]  w_strb1;
    logic [XLEN-1:0]   w_raw;
    logic [XLEN-1:0]   w_ext;

    assign w_op_ok = (op != 2'b11) || (XLEN == 64);
    assign w_off   = addr[OFFW-1:0];
    assign w_sh    = {w_off, 3'b000};
    assign w_rsh   = {r_off, 3'b000};
    assign w_base  = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};

    // access size in bytes from op
    always_comb begin
        w_nbytes = 4'd1;
        case (op)
            2'b00:   w_nbytes = 4'd1;
            2'b01:   w_nbytes = 4'd2;
            2'b10:   w_nbytes = 4'd4;
            default: w_nbytes = 4'd8;
        endcase
    end

`ifdef MEM_ACCESS_UNIT_SPLIT_EN
    logic              r_split;
    logic [XLEN-1:0]   r_rdata1;
    logic [XLEN-1:0]   r_wdata2;
    logic [BYTES-1:0]  r_wstrb2;
    logic              w_cross;
    logic [2*XLEN-1:0]  w_wdata_full;
    logic [2*BYTES-1:0] w_mask2;
    logic [2*BYTES-1:0] w_strb_full;
    logic [XLEN-1:0]   w_lo, w_hi;

    // data and strobes laid out over two bus words; upper half feeds BEAT2 at lane 0
    assign w_cross      = (int'(w_off) + int'(w_nbytes)) > BYTES;
    assign w_wdata_full = {{XLEN{1'b0}}, in} << w_sh;
    assign w_mask2      = ((2*BYTES)'(1) << w_nbytes) - (2*BYTES)'(1);
    assign w_strb_full  = w_mask2 << w_off;
    assign w_wdata1     = w_wdata_full[XLEN-1:0];
    assign w_strb1      = w_strb_full[BYTES-1:0];
    assign w_lo         = (r_state == BEAT2) ? r_rdata1 : bus_rdata;
    assign w_hi         = (r_state == BEAT2) ? bus_rdata : {XLEN{1'b0}};
    assign w_raw        = XLEN'({w_hi, w_lo} >> w_rsh);
`else
    logic              w_misal;
    logic [BYTES-1:0]  w_mask;

    assign w_misal  = |(w_off & OFFW'(w_nbytes - 4'd1));
    assign w_mask   = (BYTES'(1) << w_nbytes) - BYTES'(1);
    assign w_wdata1 = in << w_sh;
    assign w_strb1  = w_mask << w_off;
    assign w_raw    = bus_rdata >> w_rsh;
`endif

    // size mask then zero/sign extension of the right-aligned load data
    always_comb begin
        w_ext = w_raw;
        case (r_op)
            2'b00:   w_ext = r_uns ? XLEN'(w_raw[7:0])  : XLEN'($signed(w_raw[7:0]));
            2'b01:   w_ext = r_uns ? XLEN'(w_raw[15:0]) : XLEN'($signed(w_raw[15:0]));
            2'b10:   w_ext = r_uns ? XLEN'(w_raw[31:0]) : XLEN'($signed(w_raw[31:0]));
            default: w_ext = w_raw;
        endcase
    end

    // request FSM with registered bus and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_op_fault     <= 1'b0;
            r_addr_fault   <= 1'b0;
            r_access_fault <= 1'b0;
            r_out          <= '0;
            r_bus_req      <= 1'b0;
            r_bus_we       <= 1'b0;
            r_bus_addr     <= '0;
            r_bus_wdata    <= '0;
            r_bus_wstrb    <= '0;
            r_cnt          <= '0;
            r_op           <= '0;
            r_uns          <= 1'b0;
            r_we           <= 1'b0;
            r_off          <= '0;
`ifdef MEM_ACCESS_UNIT_SPLIT_EN
            r_split        <= 1'b0;
            r_rdata1       <= '0;
            r_wdata2       <= '0;
            r_wstrb2       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (available) begin
                        r_op           <= op;
                        r_uns          <= is_unsigned;
                        r_we           <= is_write;
                        r_off          <= w_off;
                        r_op_fault     <= 1'b0;
                        r_addr_fault   <= 1'b0;
                        r_access_fault <= 1'b0;
                        r_out          <= '0;
                        if (!w_op_ok) begin
                            r_op_fault <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= DONE;
                        end
`ifndef MEM_ACCESS_UNIT_SPLIT_EN
                        else if (w_misal) begin
                            r_addr_fault <= 1'b1;
                            r_done       <= 1'b1;
                            r_state      <= DONE;
                        end
`endif
                        else begin
                            r_state     <= BEAT1;
                            r_busy      <= 1'b1;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= is_write;
                            r_bus_addr  <= w_base;
                            r_bus_wdata <= w_wdata1;
                            r_bus_wstrb <= w_strb1;
                            r_cnt       <= 8'(TIMEOUT - 1);
`ifdef MEM_ACCESS_UNIT_SPLIT_EN
                            r_split     <= w_cross;
                            r_wdata2    <= w_wdata_full[2*XLEN-1:XLEN];
                            r_wstrb2    <= w_strb_full[2*BYTES-1:BYTES];
`endif
                        end
                    end
                end
                BEAT1, BEAT2: begin
                    if (bus_err || (!bus_ack && r_cnt == 8'd0)) begin
                        r_bus_req      <= 1'b0;
                        r_busy         <= 1'b0;
                        r_access_fault <= 1'b1;
                        r_out          <= '0;
                        r_done         <= 1'b1;
                        r_state        <= DONE;
                    end else if (bus_ack) begin
`ifdef MEM_ACCESS_UNIT_SPLIT_EN
                        if (r_state == BEAT1 && r_split) begin
                            r_rdata1    <= bus_rdata;
                            r_bus_addr  <= r_bus_addr + XLEN'(BYTES);
                            r_bus_wdata <= r_wdata2;
                            r_bus_wstrb <= r_wstrb2;
                            r_cnt       <= 8'(TIMEOUT - 1);
                            r_state     <= BEAT2;
                        end else
`endif
                        begin
                            r_bus_req <= 1'b0;
                            r_busy    <= 1'b0;
                            r_out     <= r_we ? '0 : w_ext;
                            r_done    <= 1'b1;
                            r_state   <= DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out          = r_out;
    assign busy         = r_busy;
    assign done         = r_done;
    assign op_fault     = r_op_fault;
    assign addr_fault   = r_addr_fault;
    assign access_fault = r_access_fault;
    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign bus_wstrb    = r_bus_wstrb;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit at XLEN=32, TIMEOUT=4.
module tb_mem_access_unit;
    localparam int XLEN    = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset, available, is_write, is_unsigned;
    logic [1:0]        op;
    logic [XLEN-1:0]   addr, in, out;
    logic              busy, done, op_fault, addr_fault, access_fault;
    logic              bus_req, bus_we;
    logic [XLEN-1:0]   bus_addr, bus_wdata, bus_rdata;
    logic [XLEN/8-1:0] bus_wstrb;
    logic              bus_ack, bus_err;

    mem_access_unit #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .available(available), .is_write(is_write),
        .is_unsigned(is_unsigned), .op(op), .addr(addr), .in(in), .out(out),
        .busy(busy), .done(done), .op_fault(op_fault), .addr_fault(addr_fault),
        .access_fault(access_fault), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] res_out;
    logic [2:0]  res_faults;
    int          res_lat, res_reqc, res_beats;
    logic        res_busy, res_we;
    logic [31:0] res_baddr [2];
    logic [31:0] res_bwdata[2];
    logic [3:0]  res_bstrb [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one request and act as the bus slave. ack_after = request cycle of each
    // beat on which the response is driven (0 = never respond).
    task automatic access(input string tag, input logic wr, input logic uns,
                          input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                          input int ack_after, input logic ack_v, input logic err_v,
                          input logic [31:0] rd0, input logic [31:0] rd1);
        int reqc;
        logic seen_done;
        available = 1'b1; is_write = wr; is_unsigned = uns; op = o; addr = a; in = d;
        reqc = 0; seen_done = 1'b0;
        res_lat = 0; res_reqc = 0; res_beats = 0; res_busy = 1'b0; res_we = 1'bx;
        res_out = 'x; res_faults = 'x;
        for (int k = 0; k < 2; k++) begin
            res_baddr[k] = 'x; res_bwdata[k] = 'x; res_bstrb[k] = 'x;
        end
        for (int i = 1; i <= 40 && !seen_done; i++) begin
            @(posedge clk); #1;
            if (bus_ack || bus_err) begin
                bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
                res_beats++; reqc = 0;
            end
            if (done) begin
                seen_done  = 1'b1;
                res_lat    = i;
                res_out    = out;
                res_faults = {op_fault, addr_fault, access_fault};
                available  = 1'b0;
            end else if (bus_req) begin
                if (reqc == 0 && res_beats < 2) begin
                    res_baddr[res_beats]  = bus_addr;
                    res_bwdata[res_beats] = bus_wdata;
                    res_bstrb[res_beats]  = bus_wstrb;
                    res_busy = busy;
                    res_we   = bus_we;
                end
                reqc++; res_reqc++;
                if (ack_after != 0 && reqc == ack_after) begin
                    bus_ack = ack_v; bus_err = err_v;
                    bus_rdata = (res_beats == 0) ? rd0 : rd1;
                end
            end
        end
        if (!seen_done) begin
            vectors++; miscompares++;
            $error("FAIL %s_timeout: observed no done, expected done within 40 cycles", tag);
            available = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
        end
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; available = 1'b0; is_write = 1'b0; is_unsigned = 1'b0;
        op = 2'b00; addr = '0; in = '0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {26'd0, busy, done, op_fault, addr_fault, access_fault, bus_req}, 32'd0);
        check("reset_out", out, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // LB / LBU at byte 3
        access("lb", 1'b0, 1'b0, 2'b00, 32'h1003, 32'h0, 1, 1'b1, 1'b0, 32'h80FF_FFFF, 32'h0);
        check("lb_out", res_out, 32'hFFFF_FF80);
        check("lb_faults", {29'd0, res_faults}, 32'd0);
        check("lb_addr", res_baddr[0], 32'h0000_1000);
        check("lb_strb", {28'd0, res_bstrb[0]}, 32'h8);
        check("lb_busy_we", {30'd0, res_busy, res_we}, 32'h2);
        access("lbu", 1'b0, 1'b1, 2'b00, 32'h1003, 32'h0, 1, 1'b1, 1'b0, 32'h80FF_FFFF, 32'h0);
        check("lbu_out", res_out, 32'h0000_0080);
        check("lbu_faults", {29'd0, res_faults}, 32'd0);

        // SH at 0x2002, ack on third request cycle
        access("sh", 1'b1, 1'b0, 2'b01, 32'h2002, 32'h0000_BEEF, 3, 1'b1, 1'b0, 32'h0, 32'h0);
        check("sh_addr", res_baddr[0], 32'h0000_2000);
        check("sh_wdata", res_bwdata[0], 32'hBEEF_0000);
        check("sh_strb", {28'd0, res_bstrb[0]}, 32'hC);
        check("sh_we", {31'd0, res_we}, 32'd1);
        check("sh_lat", res_lat, 32'd4);
        check("sh_reqc", res_reqc, 32'd3);
        check("sh_out", res_out, 32'd0);

        // LH / LHU at 0x2002, LW at 0x3000, SB at 0x5001
        access("lh", 1'b0, 1'b0, 2'b01, 32'h2002, 32'h0, 1, 1'b1, 1'b0, 32'h8001_1234, 32'h0);
        check("lh_out", res_out, 32'hFFFF_8001);
        access("lhu", 1'b0, 1'b1, 2'b01, 32'h2002, 32'h0, 1, 1'b1, 1'b0, 32'h8001_1234, 32'h0);
        check("lhu_out", res_out, 32'h0000_8001);
        access("lw", 1'b0, 1'b0, 2'b10, 32'h3000, 32'h0, 2, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0);
        check("lw_out", res_out, 32'hDEAD_BEEF);
        check("lw_strb", {28'd0, res_bstrb[0]}, 32'hF);
        access("sb", 1'b1, 1'b0, 2'b00, 32'h5001, 32'hFFFF_FFA5, 1, 1'b1, 1'b0, 32'h1234_5678, 32'h0);
        check("sb_wdata", res_bwdata[0], 32'hFFFF_A500);
        check("sb_strb", {28'd0, res_bstrb[0]}, 32'h2);
        check("sb_out", res_out, 32'd0);

        // op fault, no bus traffic, done one cycle after accept
        access("op11", 1'b0, 1'b0, 2'b11, 32'h3000, 32'h0, 1, 1'b1, 1'b0, 32'h0, 32'h0);
        check("op11_faults", {29'd0, res_faults}, 32'h4);
        check("op11_lat", res_lat, 32'd1);
        check("op11_reqc", res_reqc, 32'd0);
        check("op11_out", res_out, 32'd0);

`ifndef MEM_ACCESS_UNIT_SPLIT_EN
        access("lw_mis", 1'b0, 1'b0, 2'b10, 32'h3001, 32'h0, 1, 1'b1, 1'b0, 32'h0, 32'h0);
        check("lw_mis_faults", {29'd0, res_faults}, 32'h2);
        check("lw_mis_lat", res_lat, 32'd1);
        check("lw_mis_reqc", res_reqc, 32'd0);
        access("sh_mis", 1'b1, 1'b0, 2'b01, 32'h2001, 32'h1234, 1, 1'b1, 1'b0, 32'h0, 32'h0);
        check("sh_mis_faults", {29'd0, res_faults}, 32'h2);
`else
        access("lw_split", 1'b0, 1'b0, 2'b10, 32'h3003, 32'h0, 1, 1'b1, 1'b0, 32'hAA00_0000, 32'h00CC_BBDD);
        check("split_out", res_out, 32'hCCBB_DDAA);
        check("split_addr0", res_baddr[0], 32'h0000_3000);
        check("split_addr1", res_baddr[1], 32'h0000_3004);
        check("split_strb", {24'd0, res_bstrb[1], res_bstrb[0]}, 32'h78);
        check("split_faults", {29'd0, res_faults}, 32'd0);
        access("lh_inword", 1'b0, 1'b0, 2'b01, 32'h1001, 32'h0, 1, 1'b1, 1'b0, 32'h00AB_CD00, 32'h0);
        check("lh_inword_out", res_out, 32'hFFFF_ABCD);
        check("lh_inword_beats", res_beats, 32'd1);
`endif

        // timeout: four request cycles then access fault
        access("tmo", 1'b0, 1'b0, 2'b10, 32'h4000, 32'h0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("tmo_reqc", res_reqc, 32'd4);
        check("tmo_lat", res_lat, 32'd5);
        check("tmo_faults", {29'd0, res_faults}, 32'h1);
        check("tmo_out", res_out, 32'd0);

        // bus error, and ack+err together (err wins)
        access("err", 1'b0, 1'b0, 2'b10, 32'h6000, 32'h0, 1, 1'b0, 1'b1, 32'h1111_1111, 32'h0);
        check("err_faults", {29'd0, res_faults}, 32'h1);
        check("err_out", res_out, 32'd0);
        access("ackerr", 1'b0, 1'b0, 2'b10, 32'h6000, 32'h0, 2, 1'b1, 1'b1, 32'h2222_2222, 32'h0);
        check("ackerr_faults", {29'd0, res_faults}, 32'h1);
        check("ackerr_out", res_out, 32'd0);

        // reset in BEAT1 abandons the access
        begin
            logic saw_done;
            available = 1'b1; is_write = 1'b0; is_unsigned = 1'b0; op = 2'b10; addr = 32'h4000;
            @(posedge clk); #1;
            check("rst_pre", {30'd0, busy, bus_req}, 32'h3);
            reset = 1'b1; available = 1'b0;
            @(posedge clk); #1;
            check("rst_mid", {29'd0, bus_req, busy, done}, 32'd0);
            reset = 1'b0;
            saw_done = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                saw_done = saw_done | done | bus_req;
            end
            check("rst_no_done", {31'd0, saw_done}, 32'd0);
        end
        access("post_rst", 1'b0, 1'b1, 2'b01, 32'h4002, 32'h0, 1, 1'b1, 1'b0, 32'hCAFE_0000, 32'h0);
        check("post_rst_out", res_out, 32'h0000_CAFE);
        check("post_rst_faults", {29'd0, res_faults}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
